// File: rtl/prodacc_pkg.sv
// Shared types and default widths for the product accumulator slice.
// Optional feature macro used by this slice: PRODACC_SATURATE_EN.
package prodacc_pkg;

  localparam int DEF_PROD_W    = 8;
  localparam int DEF_ACC_W     = 16;
  localparam int DEF_BLOCK_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } prodacc_state_e;

  function automatic int cnt_width(input int block_len);
    return $clog2(block_len + 1);
  endfunction

endpackage

// File: rtl/prodacc_if.sv
// Product-in / block-result-out handshake bundle for product_accumulator.
// The master side drives products and consumes results; the slave side is the accumulator.
interface prodacc_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid,
    output in_product,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_count,
    output out_ovf
  );

endinterface

// File: rtl/prodacc_add.sv
// Accumulator adder: ACC_W-bit sum of running total plus zero-extended product, with carry out.
// With PRODACC_SATURATE_EN defined the sum clamps to all-ones on carry, otherwise it wraps.
module prodacc_add #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  // Once clamped, any further non-zero addend carries again, so a saturated block stays at max.
  always_comb begin
    wide  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
    carry = wide[ACC_W];
`ifdef PRODACC_SATURATE_EN
    sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of BLOCK_LEN products (or shorter, ended by flush) and hands the block sum downstream.
// Optional macro PRODACC_SATURATE_EN selects clamping instead of wrapping on overflow.
module product_accumulator
  import prodacc_pkg::*;
#(
  parameter int PROD_W    = DEF_PROD_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input logic     clk,
  input logic     rst,
  prodacc_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic             ready;
  logic             accept;
  logic [CNT_W-1:0] count_inc;
  logic             count_full;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  prodacc_add #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc   (acc),
    .addend(bus.in_product),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Ready is held low during reset so no beat can slip in while state is being cleared.
  always_comb begin
    ready      = (state != S_HOLD) & ~rst;
    accept     = bus.in_valid & ready;
    count_inc  = count + 1'b1;
    count_full = (count_inc == CNT_W'(BLOCK_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc   <= add_sum;
            count <= count_inc;
            ovf   <= ovf | add_carry;
            state <= (count_full || bus.flush) ? S_HOLD : S_ACCUM;
          end else if (bus.flush && (state == S_ACCUM)) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Result registers double as the output; they stay frozen until the handoff edge.
          if (bus.out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized checks of product_accumulator: defaults (ACC_W=16, BLOCK_LEN=4)
// plus a narrow instance (ACC_W=10, BLOCK_LEN=8) for overflow; honours PRODACC_SATURATE_EN.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  prodacc_if #(.PROD_W(8), .ACC_W(16), .CNT_W(3)) bus0 ();
  prodacc_if #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) bus1 ();

  product_accumulator #(.PROD_W(8), .ACC_W(16), .BLOCK_LEN(4), .CNT_W(3)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(10), .BLOCK_LEN(8), .CNT_W(4)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

`ifdef PRODACC_SATURATE_EN
  localparam int EXP_N_SUM5 = 1023;
  localparam int EXP_N_SUM8 = 1023;
`else
  localparam int EXP_N_SUM5 = 101;
  localparam int EXP_N_SUM8 = 776;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One beat on the default instance, held for exactly one edge.
  task automatic apply_stimulus(input logic [7:0] p, input logic fl);
    bus0.in_valid   = 1'b1;
    bus0.in_product = p;
    bus0.flush      = fl;
    tick();
    bus0.in_valid = 1'b0;
    bus0.flush    = 1'b0;
  endtask

  task automatic apply_stimulus_n(input logic [7:0] p);
    bus1.in_valid   = 1'b1;
    bus1.in_product = p;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    int blocks;
    int cycles;
    int m_acc;
    int m_cnt;
    int m_sum;
    bit m_ovf;
    bit m_hold;

    bus0.in_valid = 1'b0; bus0.in_product = '0; bus0.flush = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_product = '0; bus1.flush = 1'b0; bus1.out_ready = 1'b0;

    // Reset values
    tick();
    tick();
    check_output("rst_in_ready", bus0.in_ready, 0);
    check_output("rst_out_valid", bus0.out_valid, 0);
    check_output("rst_out_sum", bus0.out_sum, 0);
    check_output("rst_out_count", bus0.out_count, 0);
    check_output("rst_out_ovf", bus0.out_ovf, 0);
    rst = 1'b0;
    #1;
    check_output("rel_in_ready", bus0.in_ready, 1);

    // Four beats of 225 with out_ready held high
    $display("[TB] full block of 225");
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output("full_no_valid_early", bus0.out_valid, 0);
      apply_stimulus(8'd225, 1'b0);
    end
    check_output("full_valid", bus0.out_valid, 1);
    check_output("full_sum", bus0.out_sum, 900);
    check_output("full_count", bus0.out_count, 4);
    check_output("full_ovf", bus0.out_ovf, 0);
    check_output("full_ready_low", bus0.in_ready, 0);
    tick();
    check_output("full_handoff_valid", bus0.out_valid, 0);
    check_output("full_handoff_ready", bus0.in_ready, 1);
    check_output("full_handoff_sum", bus0.out_sum, 0);
    bus0.out_ready = 1'b0;

    // Narrow accumulator overflow (wrap or saturate)
    $display("[TB] overflow on ACC_W=10 instance");
    for (int i = 0; i < 4; i++) apply_stimulus_n(8'd225);
    check_output("ovf_sum4", bus1.out_sum, 900);
    check_output("ovf_flag4", bus1.out_ovf, 0);
    apply_stimulus_n(8'd225);
    check_output("ovf_sum5", bus1.out_sum, EXP_N_SUM5);
    check_output("ovf_flag5", bus1.out_ovf, 1);
    for (int i = 0; i < 3; i++) apply_stimulus_n(8'd225);
    check_output("ovf_valid8", bus1.out_valid, 1);
    check_output("ovf_sum8", bus1.out_sum, EXP_N_SUM8);
    check_output("ovf_count8", bus1.out_count, 8);
    check_output("ovf_flag8", bus1.out_ovf, 1);
    bus1.out_ready = 1'b1;
    tick();
    check_output("ovf_cleared", bus1.out_ovf, 0);
    check_output("ovf_handoff_valid", bus1.out_valid, 0);
    bus1.out_ready = 1'b0;

    // Backpressure: result held stable, no beat accepted until handoff
    $display("[TB] backpressure");
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i), 1'b0);
    check_output("bp_valid", bus0.out_valid, 1);
    check_output("bp_sum", bus0.out_sum, 10);
    check_output("bp_count", bus0.out_count, 4);
    bus0.in_valid   = 1'b1;
    bus0.in_product = 8'd7;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_ready_low", bus0.in_ready, 0);
      check_output("bp_sum_stable", bus0.out_sum, 10);
      check_output("bp_valid_stable", bus0.out_valid, 1);
      tick();
    end
    bus0.out_ready = 1'b1;
    tick();
    check_output("bp_after_handoff_ready", bus0.in_ready, 1);
    check_output("bp_after_handoff_valid", bus0.out_valid, 0);
    check_output("bp_after_handoff_count", bus0.out_count, 0);
    bus0.out_ready = 1'b0;
    tick();
    bus0.in_valid = 1'b0;
    check_output("bp_new_beat_count", bus0.out_count, 1);
    check_output("bp_new_beat_sum", bus0.out_sum, 7);
    bus0.flush = 1'b1;
    tick();
    bus0.flush = 1'b0;
    check_output("bp_flush_valid", bus0.out_valid, 1);
    check_output("bp_flush_count", bus0.out_count, 1);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;

    // Flush with the second beat, then flush in IDLE
    $display("[TB] flush");
    apply_stimulus(8'd10, 1'b0);
    apply_stimulus(8'd20, 1'b1);
    check_output("flush_valid", bus0.out_valid, 1);
    check_output("flush_sum", bus0.out_sum, 30);
    check_output("flush_count", bus0.out_count, 2);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    bus0.flush = 1'b1;
    tick();
    check_output("idle_flush_valid", bus0.out_valid, 0);
    tick();
    bus0.flush = 1'b0;
    check_output("idle_flush_valid2", bus0.out_valid, 0);
    check_output("idle_flush_count", bus0.out_count, 0);

    // Reset mid-block discards partial data
    $display("[TB] reset mid-block");
    for (int i = 0; i < 3; i++) apply_stimulus(8'd9, 1'b0);
    check_output("mid_count3", bus0.out_count, 3);
    rst = 1'b1;
    #1;
    check_output("mid_rst_count", bus0.out_count, 0);
    check_output("mid_rst_sum", bus0.out_sum, 0);
    check_output("mid_rst_ready", bus0.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check_output("mid_rel_ready", bus0.in_ready, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(8'd5, 1'b0);
    check_output("mid_valid", bus0.out_valid, 1);
    check_output("mid_sum", bus0.out_sum, 20);
    check_output("mid_count", bus0.out_count, 4);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;

    // Random traffic against a reference model of the block protocol
    $display("[TB] random traffic");
    blocks = 0; cycles = 0;
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
    while (blocks < 200 && cycles < 20000) begin
      cycles++;
      bus0.in_valid   = ($urandom_range(0, 3) != 0);
      bus0.in_product = 8'($urandom_range(0, 255));
      bus0.flush      = ($urandom_range(0, 7) == 0);
      bus0.out_ready  = ($urandom_range(0, 2) != 0);
      check_output("rnd_out_valid", bus0.out_valid, 32'(m_hold));
      if (m_hold) begin
        if (bus0.out_ready) begin
          check_output("rnd_sum", bus0.out_sum, m_acc);
          check_output("rnd_count", bus0.out_count, m_cnt);
          check_output("rnd_ovf", bus0.out_ovf, 32'(m_ovf));
          blocks++;
          m_acc = 0; m_cnt = 0; m_ovf = 1'b0; m_hold = 1'b0;
        end
      end else if (bus0.in_valid) begin
        m_sum = m_acc + int'(bus0.in_product);
        if (m_sum > 65535) begin
          m_ovf = 1'b1;
`ifdef PRODACC_SATURATE_EN
          m_sum = 65535;
`else
          m_sum = m_sum % 65536;
`endif
        end
        m_acc = m_sum;
        m_cnt++;
        if (m_cnt == 4 || bus0.flush) m_hold = 1'b1;
      end else if (bus0.flush && m_cnt > 0) begin
        m_hold = 1'b1;
      end
      tick();
    end
    check_output("rnd_blocks_done", blocks, 200);
    bus0.in_valid = 1'b0;
    bus0.flush    = 1'b0;
    bus0.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
